gshare_predictor: RTL and testbench

- Decode-stage conditional-branch direction predictor: 2-bit saturating-counter PHT indexed gshare-style, i.e. index = PC[IDX_W+1:2] XOR GHR.
- Produces D_predict and D_addr_PHT, which the ID/EX register carries into EX.
- Consumes the EX-stage resolution (E_branch, E_predict, E_addr_PHT, actual outcome) to train the PHT and repair speculative history.
- Raises the mispredict flag consumed by the hazard/flush logic.

---
 rtl/gshare_pkg.sv | 22 ++
 rtl/gshare_predictor_if.sv | 25 ++
 rtl/gshare_predictor_pht_array.sv | 42 ++++
 rtl/gshare_predictor.sv | 63 ++++++
 tb/tb_gshare_predictor.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared counter encodings, default index width and saturating update
package gshare_pkg;

  localparam int IDX_W_DEF = 8;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// rtl/gshare_predictor_if.sv - decode/execute predictor signal bundle with master and slave views
interface gshare_predictor_if #(
  parameter int IDX_W = gshare_pkg::IDX_W_DEF
);
  logic [31:0]      D_PC_cur;
  logic             D_branch;
  logic             D_fire;
  logic             D_predict;
  logic [IDX_W-1:0] D_addr_PHT;
  logic             E_branch;
  logic             E_predict;
  logic [IDX_W-1:0] E_addr_PHT;
  logic             E_taken;
  logic             E_mispredict;

  modport master (
    output D_PC_cur, D_branch, D_fire, E_branch, E_predict, E_addr_PHT, E_taken,
    input  D_predict, D_addr_PHT, E_mispredict
  );

  modport slave (
    input  D_PC_cur, D_branch, D_fire, E_branch, E_predict, E_addr_PHT, E_taken,
    output D_predict, D_addr_PHT, E_mispredict
  );
endinterface

// File: rtl/gshare_predictor_pht_array.sv
// rtl/gshare_predictor_pht_array.sv - 2-bit counter table, async read, sync saturating write
// Optional write-to-read bypass on index collision under GSHARE_PHT_BYPASS_EN.
module pht_array
  import gshare_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] pht_q [DEPTH];
  logic [1:0] pht_d [DEPTH];

  always_comb begin
    pht_d = pht_q;
    if (wr_en) pht_d[wr_idx] = sat_next(pht_q[wr_idx], wr_taken);
  end

  // pht_d differs from pht_q only at wr_idx, so reading it is exactly the collision bypass
`ifdef GSHARE_PHT_BYPASS_EN
  assign rd_taken = pht_d[rd_idx][1];
`else
  assign rd_taken = pht_q[rd_idx][1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor: speculative/architectural GHR and mispredict flag
// Collision bypass selectable with GSHARE_PHT_BYPASS_EN (default: no bypass).
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter logic [1:0] CNT_INIT = WNT
) (
  input logic              clk,
  input logic              rst_n,
  gshare_predictor_if.slave bp
);
  logic [IDX_W-1:0] ghr_spec_q, ghr_spec_d;
  logic [IDX_W-1:0] ghr_arch_q, ghr_arch_d;
  logic [IDX_W-1:0] idx;
  logic             rd_taken;
  logic             mispredict;
  logic             unused_pc;

  assign unused_pc  = ^{bp.D_PC_cur[31:IDX_W+2], bp.D_PC_cur[1:0]};
  assign idx        = bp.D_PC_cur[IDX_W+1:2] ^ ghr_spec_q;
  assign mispredict = bp.E_branch & (bp.E_taken != bp.E_predict);

  assign bp.D_addr_PHT   = idx;
  assign bp.D_predict    = rd_taken;
  assign bp.E_mispredict = mispredict;

  pht_array #(
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_taken (rd_taken),
    .wr_en    (bp.E_branch),
    .wr_idx   (bp.E_addr_PHT),
    .wr_taken (bp.E_taken)
  );

  // A mispredict squashes the decode instruction, so its history shift must not land
  always_comb begin
    ghr_spec_d = ghr_spec_q;
    ghr_arch_d = ghr_arch_q;
    if (bp.E_branch) ghr_arch_d = {ghr_arch_q[IDX_W-2:0], bp.E_taken};
    if (mispredict) begin
      ghr_spec_d = {ghr_arch_q[IDX_W-2:0], bp.E_taken};
    end else if (bp.D_fire && bp.D_branch) begin
      ghr_spec_d = {ghr_spec_q[IDX_W-2:0], rd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_spec_q <= '0;
      ghr_arch_q <= '0;
    end else begin
      ghr_spec_q <= ghr_spec_d;
      ghr_arch_q <= ghr_arch_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - vector table driven bench with expected-value scoreboard
module tb_gshare_predictor;
  import gshare_pkg::*;

  localparam int IDX_W = 8;
`ifdef GSHARE_PHT_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic             rst_n;
    logic [31:0]      pc;
    logic             db;
    logic             df;
    logic             eb;
    logic             ep;
    logic [IDX_W-1:0] ea;
    logic             et;
    logic [IDX_W-1:0] x_addr;
    logic             x_pred;
    logic             x_misp;
  } vec_t;

  typedef struct {
    int               id;
    logic [IDX_W-1:0] addr;
    logic             pred;
    logic             misp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  exp_t sb[$];

  gshare_predictor_if #(.IDX_W(IDX_W)) bp();

  gshare_predictor #(
    .IDX_W    (IDX_W),
    .CNT_INIT (WNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic db, input logic df,
                              input logic eb, input logic ep, input logic [IDX_W-1:0] ea,
                              input logic et, input logic [IDX_W-1:0] xa, input logic xp,
                              input logic xm);
    vec_t v;
    v.rst_n = r; v.pc = pc; v.db = db; v.df = df; v.eb = eb; v.ep = ep; v.ea = ea; v.et = et;
    v.x_addr = xa; v.x_pred = xp; v.x_misp = xm;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bp.D_PC_cur = '0; bp.D_branch = 1'b0; bp.D_fire = 1'b0;
    bp.E_branch = 1'b0; bp.E_predict = 1'b0; bp.E_addr_PHT = '0; bp.E_taken = 1'b0;

    // reset outputs, E_mispredict gated by E_branch
    vecs.push_back(mk(0, 32'h40,  1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0));
    vecs.push_back(mk(1, 32'h40,  1, 0, 0, 1, 8'h00, 0, 8'h10, 0, 0));
    // train 0x10 taken three times; each repair rewrites ghr_spec from ghr_arch
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 0, 8'h10, 1, 8'h00, 0, 1));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 0, 8'h10, 1, 8'h01, 0, 1));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 0, 8'h10, 1, 8'h03, 0, 1));
    vecs.push_back(mk(1, 32'h5C,  1, 0, 0, 0, 8'h00, 0, 8'h10, 1, 0));
    // stalled decode holds history, one fire shifts once, fire without branch holds
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 8'h00, 0, 8'h47, 0, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 8'h00, 0, 8'h47, 0, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 8'h00, 0, 8'h47, 0, 0));
    vecs.push_back(mk(1, 32'h100, 1, 1, 0, 0, 8'h00, 0, 8'h47, 0, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 8'h00, 0, 8'h4E, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 1, 0, 0, 8'h00, 0, 8'h4E, 0, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 8'h00, 0, 8'h4E, 0, 0));
    // mid-run reset clears the trained counter immediately
    vecs.push_back(mk(0, 32'h40,  1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0));
    // build ghr_arch = 0x05 with correct predictions, then repair while decode fires
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 1, 8'h7F, 1, 8'h00, 0, 0));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 0, 8'h7F, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 1, 8'h7F, 1, 8'h00, 0, 0));
    vecs.push_back(mk(1, 32'h00,  1, 1, 1, 0, 8'h7F, 1, 8'h00, 0, 1));
    vecs.push_back(mk(1, 32'h00,  1, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0));
    // four not-taken at 0x20 saturate at 00; one taken then gives 01, not a wrapped 10
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'h00, 0, 0, 1, 0, 8'h20, 0, 8'h0B, 0, 0));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 0, 8'h20, 1, 8'h0B, 0, 1));
    vecs.push_back(mk(1, 32'h104, 1, 0, 0, 0, 8'h00, 0, 8'h20, 0, 0));
    // read/write collision at 0x33
    vecs.push_back(mk(0, 32'h40,  1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0));
    vecs.push_back(mk(1, 32'hCC,  1, 0, 1, 0, 8'h33, 1, 8'h33, BYP, 1));
    vecs.push_back(mk(1, 32'hC8,  1, 0, 0, 0, 8'h00, 0, 8'h33, 1, 0));
    vecs.push_back(mk(1, 32'h00,  0, 0, 1, 1, 8'h33, 0, 8'h01, 0, 1));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n          = vecs[i].rst_n;
      bp.D_PC_cur    = vecs[i].pc;
      bp.D_branch    = vecs[i].db;
      bp.D_fire      = vecs[i].df;
      bp.E_branch    = vecs[i].eb;
      bp.E_predict   = vecs[i].ep;
      bp.E_addr_PHT  = vecs[i].ea;
      bp.E_taken     = vecs[i].et;
      e.id = i; e.addr = vecs[i].x_addr; e.pred = vecs[i].x_pred; e.misp = vecs[i].x_misp;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard underflow at vector %0d", i);
      end else begin
        e = sb.pop_front();
        chk("D_addr_PHT",   e.id, 32'(bp.D_addr_PHT),   32'(e.addr));
        chk("D_predict",    e.id, 32'(bp.D_predict),    32'(e.pred));
        chk("E_mispredict", e.id, 32'(bp.E_mispredict), 32'(e.misp));
      end
      @(posedge clk); #1;
    end
    chk("scoreboard drained", vecs.size(), sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
